// File: rtl/banked_mem_responder_pkg.sv
// Shared constants for the banked main-memory responder and the cache FSM that drives it.
// Words are 16 bits and interleaved across four banks by the word-address LSBs.
package banked_mem_responder_pkg;

  localparam int NUM_BANKS       = 4;
  localparam int BANK_W          = 2;
  localparam int BANK_LSB        = 1;
  localparam int ROW_LSB         = 3;
  localparam int WORD_W          = 16;
  localparam int DEF_BANK_CYCLES = 4;
  localparam int DEF_RD_LAT      = 2;

endpackage

// File: rtl/banked_mem_responder_mem_bank.sv
// One memory bank: word array, occupancy counter and synchronous read register.
// The read register is the first stage of the read-latency pipeline.
module mem_bank
  import banked_mem_responder_pkg::*;
#(
  parameter int DEPTH_W     = 13,
  parameter int BANK_CYCLES = DEF_BANK_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               acc,
  input  logic               we,
  input  logic [DEPTH_W-1:0] row,
  input  logic [WORD_W-1:0]  wdata,
  output logic [WORD_W-1:0]  rdata,
  output logic               busy
);

  localparam int CNT_W = (BANK_CYCLES > 1) ? $clog2(BANK_CYCLES) : 1;

  logic [WORD_W-1:0] mem_q [2**DEPTH_W];
  logic [WORD_W-1:0] rdata_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (acc) begin
      cnt_d = CNT_W'(BANK_CYCLES - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // NOTE: the array and read register have no reset; contents survive rst and map onto plain RAM.
  always_ff @(posedge clk) begin
    if (acc && we) mem_q[row] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (acc && !we) rdata_q <= mem_q[row];
  end

  assign rdata = rdata_q;
  assign busy  = (cnt_q != '0);

endmodule

// File: rtl/banked_mem_responder.sv
// Four-bank word-interleaved memory responder: request decode, stall/err, and the
// read-valid/data pipeline that muxes the four bank read registers.
module banked_mem_responder
  import banked_mem_responder_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DEPTH_W     = 13,
  parameter int BANK_CYCLES = DEF_BANK_CYCLES,
  parameter int RD_LAT      = DEF_RD_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       data_in,
  input  logic              wr,
  input  logic              rd,
  output logic [15:0]       data_out,
  output logic              rd_valid,
  output logic              stall,
  output logic [3:0]        busy,
  output logic              err
);

  logic               legal;
  logic               accept;
  logic [BANK_W-1:0]  bank_sel;
  logic [DEPTH_W-1:0] row;
  logic [WORD_W-1:0]  bank_rdata [NUM_BANKS];
  logic [WORD_W-1:0]  mux_data;
  logic [WORD_W-1:0]  out_data;

  logic [RD_LAT-1:0]  vld_q, vld_d;
  logic [BANK_W-1:0]  sel_q, sel_d;

  assign bank_sel = addr[BANK_LSB +: BANK_W];
  assign row      = addr[ROW_LSB +: DEPTH_W];
  assign legal    = (rd ^ wr) & ~addr[0];
  assign err      = (rd & wr) | ((rd | wr) & addr[0]);
  assign stall    = legal & busy[bank_sel];
  // Nothing is accepted on a reset edge so the counters and pipeline come out truly idle.
  assign accept   = legal & ~busy[bank_sel] & ~rst;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    mem_bank #(
      .DEPTH_W    (DEPTH_W),
      .BANK_CYCLES(BANK_CYCLES)
    ) u_bank (
      .clk  (clk),
      .rst  (rst),
      .acc  (accept && (bank_sel == BANK_W'(b))),
      .we   (wr),
      .row  (row),
      .wdata(data_in),
      .rdata(bank_rdata[b]),
      .busy (busy[b])
    );
  end

  always_comb begin
    vld_d    = '0;
    vld_d[0] = accept & rd;
    for (int i = 1; i < RD_LAT; i++) vld_d[i] = vld_q[i-1];
    sel_d    = (accept & rd) ? bank_sel : sel_q;
  end

  always_ff @(posedge clk) begin
    if (rst) vld_q <= '0;
    else     vld_q <= vld_d;
  end

  always_ff @(posedge clk) begin
    sel_q <= sel_d;
  end

  assign mux_data = bank_rdata[sel_q];

  // Stage 1 is the bank read register; stages 2..RD_LAT carry the muxed word.
  if (RD_LAT == 1) begin : g_lat1
    assign out_data = mux_data;
  end else begin : g_latn
    logic [WORD_W-1:0] dat_q [RD_LAT-1];
    logic [WORD_W-1:0] dat_d [RD_LAT-1];

    always_comb begin
      dat_d[0] = mux_data;
      for (int i = 1; i < RD_LAT - 1; i++) dat_d[i] = dat_q[i-1];
    end

    always_ff @(posedge clk) begin
      dat_q <= dat_d;
    end

    assign out_data = dat_q[RD_LAT-2];
  end

  assign rd_valid = vld_q[RD_LAT-1];
  assign data_out = rd_valid ? out_data : 16'h0000;

endmodule
